inv_table_loader: RTL and testbench

//  Write-side master for the 1024x36 reciprocal constant/gradient table.

---
 rtl/inv_table_loader.sv | 182 ++++++++++++++++++
 tb/tb_inv_table_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_table_loader.sv
// Byte-stream loader for the reciprocal table: packs 5 big-endian bytes per entry and writes DEPTH entries.
// Define TBL_VERIFY_EN to add a read-back check (VRD/VCMP) after every write with sticky error reporting.
module inv_table_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 36
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tbl_we,
    output logic [ADDR_W-1:0] tbl_addr,
    output logic [DATA_W-1:0] tbl_din,
    input  logic [DATA_W-1:0] tbl_dout,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef TBL_VERIFY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_RECV, S_WRITE, S_VRD, S_VCMP, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_RECV, S_WRITE, S_DONE
    } state_t;
`endif

    state_t            r_state;
    state_t            w_nextState;
    logic [2:0]        r_byteCnt;
    logic [31:0]       r_shift;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_tblAddr;
    logic [DATA_W-1:0] r_tblDin;
    logic [39:0]       w_word;
    logic              w_startLoad;
    logic              w_byteTake;
    logic              w_loadWord;
    logic              w_advance;
    logic              w_isLast;
    logic              w_unused;
`ifdef TBL_VERIFY_EN
    logic              w_checkWord;
`endif

    // The fifth byte is taken straight from the input so the word is ready when WRITE begins.
    assign w_word   = {r_shift, in_data};
    assign w_isLast = (r_addr == LAST_ADDR);
    assign tbl_addr = r_tblAddr;
    assign tbl_din  = r_tblDin;
    assign w_unused = ^{w_word, tbl_dout};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        tbl_we      = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        w_startLoad = 1'b0;
        w_byteTake  = 1'b0;
        w_loadWord  = 1'b0;
        w_advance   = 1'b0;
`ifdef TBL_VERIFY_EN
        w_checkWord = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_startLoad = 1'b1;
                    w_nextState = S_RECV;
                end
            end
            S_RECV: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_byteTake = 1'b1;
                    if (r_byteCnt == 3'd4) begin
                        w_loadWord  = 1'b1;
                        w_nextState = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                tbl_we = 1'b1;
`ifdef TBL_VERIFY_EN
                w_nextState = S_VRD;
`else
                w_advance   = 1'b1;
                w_nextState = w_isLast ? S_DONE : S_RECV;
`endif
            end
`ifdef TBL_VERIFY_EN
            S_VRD: begin
                w_nextState = S_VCMP;
            end
            S_VCMP: begin
                w_checkWord = 1'b1;
                w_advance   = 1'b1;
                w_nextState = w_isLast ? S_DONE : S_RECV;
            end
`endif
            S_DONE: begin
                busy        = 1'b0;
                done        = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // The address counter saturates at the last entry so a load can never wrap onto address 0.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_byteCnt <= '0;
            r_shift   <= '0;
            r_addr    <= '0;
            r_tblAddr <= '0;
            r_tblDin  <= '0;
        end else begin
            if (w_startLoad) begin
                r_addr    <= '0;
                r_byteCnt <= '0;
            end
            if (w_byteTake) begin
                r_shift   <= {r_shift[23:0], in_data};
                r_byteCnt <= (r_byteCnt == 3'd4) ? 3'd0 : r_byteCnt + 3'd1;
            end
            if (w_loadWord) begin
                r_tblAddr <= r_addr;
                r_tblDin  <= w_word[DATA_W-1:0];
            end
            if (w_advance && !w_isLast) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

`ifdef TBL_VERIFY_EN
    logic              r_error;
    logic [ADDR_W-1:0] r_errAddr;

    // Only the first mismatch of a load is recorded; later ones leave error/err_addr untouched.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_error   <= 1'b0;
            r_errAddr <= '0;
        end else if (w_startLoad) begin
            r_error   <= 1'b0;
            r_errAddr <= '0;
        end else if (w_checkWord && !r_error && (tbl_dout != r_tblDin)) begin
            r_error   <= 1'b1;
            r_errAddr <= r_tblAddr;
        end
    end

    assign error    = r_error;
    assign err_addr = r_errAddr;
`else
    assign error    = 1'b0;
    assign err_addr = '0;
`endif

endmodule

// File: tb/tb_inv_table_loader.sv
// Directed bench for inv_table_loader with a behavioural table RAM; readback of addrs 12 and 40 is corrupted.
// Expectations adapt to TBL_VERIFY_EN so the same bench covers both builds.
module tb_inv_table_loader;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 36;
`ifdef TBL_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic              clk;
    logic              rstn;
    logic              start;
    logic [7:0]        inData;
    logic              inValid;
    logic              inReady;
    logic              tblWe;
    logic [ADDR_W-1:0] tblAddr;
    logic [DATA_W-1:0] tblDin;
    logic [DATA_W-1:0] tblDout;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] errAddr;

    int compared   = 0;
    int mismatched = 0;

    logic [DATA_W-1:0] ram    [DEPTH];
    logic [DATA_W-1:0] expMem [DEPTH];

    int                cycle       = 0;
    int                weCount     = 0;
    int                orderErr    = 0;
    int                lastWeCycle = 0;
    int                weGap       = 0;
    int                doneCount   = 0;
    int                doneCycle   = 0;
    logic              busyAtDone  = 1'b1;
    logic [ADDR_W-1:0] lastAddr    = '0;

    inv_table_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .in_data  (inData),
        .in_valid (inValid),
        .in_ready (inReady),
        .tbl_we   (tblWe),
        .tbl_addr (tblAddr),
        .tbl_din  (tblDin),
        .tbl_dout (tblDout),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_addr (errAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table model with registered read; two addresses return a flipped LSB.
    always @(posedge clk) begin
        if (tblWe === 1'b1) ram[tblAddr] <= tblDin;
        tblDout <= ram[tblAddr] ^ ((tblAddr == 10'd12 || tblAddr == 10'd40) ? 36'h1 : 36'h0);
    end

    always @(negedge clk) begin
        cycle++;
        if (tblWe === 1'b1) begin
            if (tblAddr != 0 && tblAddr != lastAddr + ADDR_W'(1)) orderErr++;
            weGap       = cycle - lastWeCycle;
            lastWeCycle = cycle;
            lastAddr    = tblAddr;
            weCount++;
        end
        if (done === 1'b1) begin
            doneCount++;
            doneCycle  = cycle;
            busyAtDone = busy;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int n = 0;
        inData  = b;
        inValid = 1'b1;
        while (inReady !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checkOutput("byteWait", 64'(n < 50), 64'd1);
        tick();
    endtask

    task automatic sendWord(input logic [39:0] w);
        for (int k = 0; k < 5; k++) applyStimulus(w[39-8*k -: 8]);
    endtask

    task automatic sendRand(input int idx);
        logic [39:0] w;
        w[39:32] = 8'($urandom);
        w[31:0]  = $urandom;
        expMem[idx] = w[DATA_W-1:0];
        sendWord(w);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        start   = 1'b0;
        inValid = 1'b0;
        inData  = 8'h00;
        rstn    = 1'b0;
        tick();
        tick();
        checkOutput("rst_in_ready", 64'(inReady), 64'd0);
        checkOutput("rst_tbl_we", 64'(tblWe), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_error", 64'(error), 64'd0);
        checkOutput("rst_err_addr", 64'(errAddr), 64'd0);
        checkOutput("rst_tbl_addr", 64'(tblAddr), 64'd0);
        checkOutput("rst_tbl_din", 64'(tblDin), 64'd0);
        rstn = 1'b1;

        // Byte 0x00 offered while idle must not be consumed early.
        inData  = 8'h00;
        inValid = 1'b1;
        tick();
        tick();
        checkOutput("idle_in_ready", 64'(inReady), 64'd0);

        $display("[TB] test 1: bytes 0x00..0x09");
        pulseStart();
        checkOutput("t1_busy", 64'(busy), 64'd1);
        sendWord(40'h00_0102_0304);
        sendWord(40'h05_0607_0809);
        tick();
        expMem[0] = 36'h0_0102_0304;
        expMem[1] = 36'h5_0607_0809;
        checkOutput("t1_ram0", 64'(ram[0]), 64'h0_0102_0304);
        checkOutput("t1_ram1", 64'(ram[1]), 64'h5_0607_0809);
        checkOutput("t1_last_addr", 64'(lastAddr), 64'd1);
        checkOutput("t1_we_gap", 64'(weGap), VERIFY ? 64'd8 : 64'd6);
        checkOutput("t1_we_count", 64'(weCount), 64'd2);
        checkOutput("t1_din_hold", 64'(tblDin), 64'h5_0607_0809);
        checkOutput("t1_addr_hold", 64'(tblAddr), 64'd1);

        $display("[TB] test 3: valid gap mid-word");
        applyStimulus(8'hA1);
        applyStimulus(8'hB2);
        inValid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            checkOutput("t3_ready_gap", 64'(inReady), 64'd1);
        end
        checkOutput("t3_no_write", 64'(weCount), 64'd2);
        applyStimulus(8'hC3);
        applyStimulus(8'hD4);
        applyStimulus(8'hE5);
        checkOutput("t3_din", 64'(tblDin), 64'h1_B2C3_D4E5);
        tick();
        expMem[2] = 36'h1_B2C3_D4E5;
        checkOutput("t3_ram2", 64'(ram[2]), 64'h1_B2C3_D4E5);

        $display("[TB] test 2/4/6: full load with start pulse at addr 37");
        for (int a = 3; a < DEPTH; a++) begin
            if (a == 13) begin
                inValid = 1'b0;
                tick();
                tick();
                tick();
                checkOutput("t6_error", 64'(error), 64'(VERIFY));
                checkOutput("t6_err_addr", 64'(errAddr), VERIFY ? 64'd12 : 64'd0);
            end
            if (a == 37) begin
                inValid = 1'b0;
                pulseStart();
                checkOutput("t4_busy", 64'(busy), 64'd1);
                checkOutput("t4_error_kept", 64'(error), 64'(VERIFY));
            end
            sendRand(a);
            if (a == 39) begin
                checkOutput("t4_last_addr", 64'(lastAddr), 64'd39);
                checkOutput("t4_order", 64'(orderErr), 64'd0);
            end
        end
        inValid = 1'b0;
        n = 0;
        while (doneCount == 0 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("t2_done_count", 64'(doneCount), 64'd1);
        checkOutput("t2_busy_at_done", 64'(busyAtDone), 64'd0);
        checkOutput("t2_done_delay", 64'(doneCycle - lastWeCycle), VERIFY ? 64'd3 : 64'd1);
        checkOutput("t2_we_count", 64'(weCount), 64'(DEPTH));
        checkOutput("t2_order", 64'(orderErr), 64'd0);
        checkOutput("t2_last_addr", 64'(lastAddr), 64'(DEPTH - 1));
        checkOutput("t6_err_addr_done", 64'(errAddr), VERIFY ? 64'd12 : 64'd0);
        checkOutput("t6_error_done", 64'(error), 64'(VERIFY));
        bad = 0;
        for (int a = 0; a < DEPTH; a++) if (ram[a] !== expMem[a]) bad++;
        checkOutput("t2_ram_content", 64'(bad), 64'd0);
        tick();
        checkOutput("t2_done_low", 64'(done), 64'd0);
        checkOutput("t2_busy_low", 64'(busy), 64'd0);
        checkOutput("t2_ready_idle", 64'(inReady), 64'd0);
        checkOutput("t2_single_done", 64'(doneCount), 64'd1);

        $display("[TB] test 5: reset mid-load");
        pulseStart();
        checkOutput("t5_error_cleared", 64'(error), 64'd0);
        checkOutput("t5_busy", 64'(busy), 64'd1);
        for (int a = 0; a < 6; a++) sendRand(a);
        inValid = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        checkOutput("t5_busy_rst", 64'(busy), 64'd0);
        checkOutput("t5_we_rst", 64'(tblWe), 64'd0);
        checkOutput("t5_ready_rst", 64'(inReady), 64'd0);
        checkOutput("t5_addr_rst", 64'(tblAddr), 64'd0);
        rstn = 1'b1;
        bad = 0;
        for (int a = 0; a < 6; a++) if (ram[a] !== expMem[a]) bad++;
        checkOutput("t5_ram_kept", 64'(bad), 64'd0);
        tick();
        pulseStart();
        sendRand(0);
        checkOutput("t5_reload_addr", 64'(tblAddr), 64'd0);
        tick();
        checkOutput("t5_reload_ram0", 64'(ram[0]), 64'(expMem[0]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
